// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit: walks each instruction through IF/ID/EXE/MEM/WB and
// decodes the datapath strobes from the current state and the IR opcode.
module multicycle_control_fsm #(
    parameter logic [5:0] OP_HALT = 6'b111111,
    parameter int         STATE_W = 3
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [5:0]         opcode,
    input  logic               zero,
    output logic               PCWre,
    output logic [1:0]         PCSrc,
    output logic               IRWre,
    output logic               RegWre,
    output logic               RegDst,
    output logic               ALUSrcB,
    output logic               ExtSel,
    output logic [2:0]         ALUOp,
    output logic               mRD,
    output logic               mWR,
    output logic               DBDataSrc,
    output logic [STATE_W-1:0] state,
    output logic               illegal
);

    // state | meaning
    // IF    | fetch, IR loads
    // ID    | decode; j and undefined opcodes retire here, halt parks
    // EXE   | ALU operation; branches resolve and retire here
    // MEM   | data memory access; sw retires here
    // WB    | register write-back and retire
    // HALT  | parked until Reset
    typedef enum logic [STATE_W-1:0] {
        ST_IF   = 3'b000,
        ST_ID   = 3'b001,
        ST_EXE  = 3'b010,
        ST_MEM  = 3'b011,
        ST_WB   = 3'b100,
        ST_HALT = 3'b111
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_J    = 6'b111000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    logic       is_rtype, is_imm, is_lw, is_sw, is_beq, is_bne, is_j, is_halt;
    logic       is_legal, use_imm, zero_ext, br_taken;
    logic [2:0] dec_alu_op;

    // Opcode classification; halt is checked first so OP_HALT may be overridden.
    always_comb begin
        is_rtype   = 1'b0;
        is_imm     = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_j       = 1'b0;
        is_halt    = 1'b0;
        zero_ext   = 1'b0;
        dec_alu_op = ALU_ADD;
        if (opcode == OP_HALT) begin
            is_halt = 1'b1;
        end else begin
            case (opcode)
                OP_ADD:  is_rtype = 1'b1;
                OP_SUB:  begin is_rtype = 1'b1; dec_alu_op = ALU_SUB; end
                OP_ADDI: is_imm = 1'b1;
                OP_OR:   begin is_rtype = 1'b1; dec_alu_op = ALU_OR;  end
                OP_AND:  begin is_rtype = 1'b1; dec_alu_op = ALU_AND; end
                OP_ORI:  begin is_imm = 1'b1; zero_ext = 1'b1; dec_alu_op = ALU_OR; end
                OP_SLT:  begin is_rtype = 1'b1; dec_alu_op = ALU_SLT; end
                OP_SW:   is_sw = 1'b1;
                OP_LW:   is_lw = 1'b1;
                OP_BEQ:  begin is_beq = 1'b1; dec_alu_op = ALU_SUB; end
                OP_BNE:  begin is_bne = 1'b1; dec_alu_op = ALU_SUB; end
                OP_J:    is_j = 1'b1;
                default: ;
            endcase
        end
    end

    assign is_legal = is_rtype | is_imm | is_lw | is_sw | is_beq | is_bne | is_j | is_halt;
    assign use_imm  = is_imm | is_lw | is_sw;
    assign br_taken = (is_beq & zero) | (is_bne & ~zero);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IF;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = ST_IF;
        illegal_d = illegal_q;
        PCWre     = 1'b0;
        PCSrc     = PC_SEQ;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        ALUOp     = ALU_ADD;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        case (state_q)
            ST_IF: begin
                // Gate with Reset so nothing loads the IR while reset is held.
                IRWre   = Reset;
                state_d = ST_ID;
            end
            ST_ID: begin
                if (is_halt) begin
                    state_d = ST_HALT;
                end else if (is_j) begin
                    PCWre   = 1'b1;
                    PCSrc   = PC_JUMP;
                    state_d = ST_IF;
                end else if (!is_legal) begin
                    PCWre     = 1'b1;
                    illegal_d = 1'b1;
                    state_d   = ST_IF;
                end else begin
                    state_d = ST_EXE;
                end
            end
            ST_EXE: begin
                ALUOp   = dec_alu_op;
                ALUSrcB = use_imm;
                ExtSel  = ~zero_ext;
                if (is_beq || is_bne) begin
                    PCWre   = 1'b1;
                    PCSrc   = br_taken ? PC_BRANCH : PC_SEQ;
                    state_d = ST_IF;
                end else if (is_lw || is_sw) begin
                    state_d = ST_MEM;
                end else if (is_rtype || is_imm) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_IF;
                end
            end
            ST_MEM: begin
                if (is_sw) begin
                    mWR     = 1'b1;
                    PCWre   = 1'b1;
                    state_d = ST_IF;
                end else begin
                    mRD     = is_lw;
                    state_d = is_lw ? ST_WB : ST_IF;
                end
            end
            ST_WB: begin
                RegWre    = 1'b1;
                PCWre     = 1'b1;
                RegDst    = is_rtype;
                DBDataSrc = is_lw;
                state_d   = ST_IF;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IF;
        endcase
    end

    assign state   = state_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: each instruction class is stepped
// cycle by cycle and the full strobe bundle compared against hand-built vectors.
module tb_multicycle_control_fsm;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HLT  = 6'b111111;
    localparam logic [5:0] OP_UND  = 6'b001111;

    logic       CLK, Reset, zero;
    logic [5:0] opcode;
    logic       PCWre, IRWre, RegWre, RegDst, ALUSrcB, ExtSel, mRD, mWR, DBDataSrc, illegal;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp, state;
    logic [16:0] outs;

    int n_cmp  = 0;
    int n_fail = 0;

    multicycle_control_fsm dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
        .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .RegWre(RegWre),
        .RegDst(RegDst), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp),
        .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .state(state), .illegal(illegal)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign outs = {state, PCWre, PCSrc, IRWre, RegWre, RegDst, ALUSrcB, ExtSel,
                   ALUOp, mRD, mWR, DBDataSrc};

    // Packs expected fields in the same order as outs.
    function automatic logic [16:0] pk(input logic [2:0] st, input logic pcw,
                                       input logic [1:0] pcs, input logic irw, rgw, rgd, asb, ext,
                                       input logic [2:0] aop, input logic mrd, mwr, dbs);
        return {st, pcw, pcs, irw, rgw, rgd, asb, ext, aop, mrd, mwr, dbs};
    endfunction

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic test_reset();
        opcode = OP_ADDI;
        zero   = 1'b0;
        Reset  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp++;
            if (outs !== 17'd0) begin
                n_fail++;
                $display("FAIL reset_outs cyc%0d: got %h want %h", k, outs, 17'd0);
            end
            n_cmp++;
            if (illegal !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_illegal: got %b want 0", illegal);
            end
        end
        Reset = 1'b1;
        #1;
        n_cmp++;
        if (outs !== pk(3'd0,0,2'b00,1,0,0,0,0,3'b000,0,0,0)) begin
            n_fail++;
            $display("FAIL reset_release_if: got %h want %h", outs, pk(3'd0,0,2'b00,1,0,0,0,0,3'b000,0,0,0));
        end
    endtask

    task automatic test_addi();
        logic [16:0] exp [4];
        exp[0] = pk(3'd0,0,2'b00,1,0,0,0,0,3'b000,0,0,0);
        exp[1] = pk(3'd1,0,2'b00,0,0,0,0,0,3'b000,0,0,0);
        exp[2] = pk(3'd2,0,2'b00,0,0,0,1,1,3'b000,0,0,0);
        exp[3] = pk(3'd4,1,2'b00,0,1,0,0,0,3'b000,0,0,0);
        opcode = OP_ADDI;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (outs !== exp[k]) begin
                n_fail++;
                $display("FAIL addi cyc%0d: got %h want %h", k, outs, exp[k]);
            end
            step();
        end
    endtask

    task automatic test_lw();
        logic [16:0] exp [5];
        exp[0] = pk(3'd0,0,2'b00,1,0,0,0,0,3'b000,0,0,0);
        exp[1] = pk(3'd1,0,2'b00,0,0,0,0,0,3'b000,0,0,0);
        exp[2] = pk(3'd2,0,2'b00,0,0,0,1,1,3'b000,0,0,0);
        exp[3] = pk(3'd3,0,2'b00,0,0,0,0,0,3'b000,1,0,0);
        exp[4] = pk(3'd4,1,2'b00,0,1,0,0,0,3'b000,0,0,1);
        opcode = OP_LW;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (outs !== exp[k]) begin
                n_fail++;
                $display("FAIL lw cyc%0d: got %h want %h", k, outs, exp[k]);
            end
            step();
        end
    endtask

    task automatic test_sw();
        logic [16:0] exp [4];
        exp[0] = pk(3'd0,0,2'b00,1,0,0,0,0,3'b000,0,0,0);
        exp[1] = pk(3'd1,0,2'b00,0,0,0,0,0,3'b000,0,0,0);
        exp[2] = pk(3'd2,0,2'b00,0,0,0,1,1,3'b000,0,0,0);
        exp[3] = pk(3'd3,1,2'b00,0,0,0,0,0,3'b000,0,1,0);
        opcode = OP_SW;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (outs !== exp[k]) begin
                n_fail++;
                $display("FAIL sw cyc%0d: got %h want %h", k, outs, exp[k]);
            end
            step();
        end
        n_cmp++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL sw_retire_to_if: got %0d want 0", state);
        end
    endtask

    task automatic test_alu_ops();
        logic [5:0]  ops [5];
        logic [16:0] exe [5];
        logic [16:0] wb  [5];
        ops[0] = OP_ADD; exe[0] = pk(3'd2,0,2'b00,0,0,0,0,1,3'b000,0,0,0);
        ops[1] = OP_SUB; exe[1] = pk(3'd2,0,2'b00,0,0,0,0,1,3'b001,0,0,0);
        ops[2] = OP_OR;  exe[2] = pk(3'd2,0,2'b00,0,0,0,0,1,3'b011,0,0,0);
        ops[3] = OP_AND; exe[3] = pk(3'd2,0,2'b00,0,0,0,0,1,3'b100,0,0,0);
        ops[4] = OP_SLT; exe[4] = pk(3'd2,0,2'b00,0,0,0,0,1,3'b110,0,0,0);
        for (int i = 0; i < 5; i++) wb[i] = pk(3'd4,1,2'b00,0,1,1,0,0,3'b000,0,0,0);
        for (int i = 0; i < 5; i++) begin
            opcode = ops[i];
            step();
            step();
            n_cmp++;
            if (outs !== exe[i]) begin
                n_fail++;
                $display("FAIL rtype_exe op=%b: got %h want %h", ops[i], outs, exe[i]);
            end
            step();
            n_cmp++;
            if (outs !== wb[i]) begin
                n_fail++;
                $display("FAIL rtype_wb op=%b: got %h want %h", ops[i], outs, wb[i]);
            end
            step();
        end
        opcode = OP_ORI;
        step();
        step();
        n_cmp++;
        if (outs !== pk(3'd2,0,2'b00,0,0,0,1,0,3'b011,0,0,0)) begin
            n_fail++;
            $display("FAIL ori_exe: got %h want %h", outs, pk(3'd2,0,2'b00,0,0,0,1,0,3'b011,0,0,0));
        end
        step();
        n_cmp++;
        if (outs !== pk(3'd4,1,2'b00,0,1,0,0,0,3'b000,0,0,0)) begin
            n_fail++;
            $display("FAIL ori_wb: got %h want %h", outs, pk(3'd4,1,2'b00,0,1,0,0,0,3'b000,0,0,0));
        end
        step();
    endtask

    task automatic test_branch();
        logic [5:0] ops [4];
        logic       zs  [4];
        logic [1:0] pcs [4];
        logic [16:0] e;
        ops[0] = OP_BEQ; zs[0] = 1'b1; pcs[0] = 2'b01;
        ops[1] = OP_BNE; zs[1] = 1'b1; pcs[1] = 2'b00;
        ops[2] = OP_BEQ; zs[2] = 1'b0; pcs[2] = 2'b00;
        ops[3] = OP_BNE; zs[3] = 1'b0; pcs[3] = 2'b01;
        for (int i = 0; i < 4; i++) begin
            opcode = ops[i];
            zero   = zs[i];
            step();
            n_cmp++;
            if (outs !== pk(3'd1,0,2'b00,0,0,0,0,0,3'b000,0,0,0)) begin
                n_fail++;
                $display("FAIL branch_id case%0d: got %h", i, outs);
            end
            step();
            e = pk(3'd2,1,pcs[i],0,0,0,0,1,3'b001,0,0,0);
            n_cmp++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL branch_exe case%0d: got %h want %h", i, outs, e);
            end
            step();
            n_cmp++;
            if (state !== 3'd0) begin
                n_fail++;
                $display("FAIL branch_next_if case%0d: got %0d want 0", i, state);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jump();
        opcode = OP_J;
        step();
        n_cmp++;
        if (outs !== pk(3'd1,1,2'b10,0,0,0,0,0,3'b000,0,0,0)) begin
            n_fail++;
            $display("FAIL jump_id: got %h want %h", outs, pk(3'd1,1,2'b10,0,0,0,0,0,3'b000,0,0,0));
        end
        step();
        n_cmp++;
        if (outs !== pk(3'd0,0,2'b00,1,0,0,0,0,3'b000,0,0,0)) begin
            n_fail++;
            $display("FAIL jump_next_if: got %h want %h", outs, pk(3'd0,0,2'b00,1,0,0,0,0,3'b000,0,0,0));
        end
    endtask

    task automatic test_reset_mid_lw();
        logic [2:0] st [4];
        opcode = OP_LW;
        for (int k = 0; k < 3; k++) step();
        n_cmp++;
        if (outs !== pk(3'd3,0,2'b00,0,0,0,0,0,3'b000,1,0,0)) begin
            n_fail++;
            $display("FAIL midlw_mem: got %h", outs);
        end
        #1 Reset = 1'b0;
        #1;
        n_cmp++;
        if (outs !== 17'd0) begin
            n_fail++;
            $display("FAIL midlw_async_reset: got %h want %h", outs, 17'd0);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (RegWre !== 1'b0 || state !== 3'd0) begin
                n_fail++;
                $display("FAIL midlw_held: RegWre=%b state=%0d want 0/0", RegWre, state);
            end
        end
        Reset = 1'b1;
        #1;
        n_cmp++;
        if (outs !== pk(3'd0,0,2'b00,1,0,0,0,0,3'b000,0,0,0)) begin
            n_fail++;
            $display("FAIL midlw_release_if: got %h", outs);
        end
        st[0] = 3'd1; st[1] = 3'd2; st[2] = 3'd3; st[3] = 3'd4;
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++;
            if (state !== st[k]) begin
                n_fail++;
                $display("FAIL midlw_rerun cyc%0d: got %0d want %0d", k + 1, state, st[k]);
            end
        end
        step();
    endtask

    task automatic test_illegal();
        opcode = OP_UND;
        step();
        n_cmp++;
        if (outs !== pk(3'd1,1,2'b00,0,0,0,0,0,3'b000,0,0,0) || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_id: got %h/%b want %h/0", outs, illegal, pk(3'd1,1,2'b00,0,0,0,0,0,3'b000,0,0,0));
        end
        step();
        n_cmp++;
        if (state !== 3'd0 || illegal !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_set: state=%0d illegal=%b want 0/1", state, illegal);
        end
        opcode = OP_ADDI;
        for (int k = 0; k < 4; k++) step();
        n_cmp++;
        if (illegal !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_sticky: got %b want 1", illegal);
        end
    endtask

    task automatic test_halt();
        opcode = OP_HLT;
        step();
        n_cmp++;
        if (outs !== pk(3'd1,0,2'b00,0,0,0,0,0,3'b000,0,0,0)) begin
            n_fail++;
            $display("FAIL halt_id: got %h", outs);
        end
        for (int k = 0; k < 20; k++) begin
            step();
            n_cmp++;
            if (outs !== pk(3'd7,0,2'b00,0,0,0,0,0,3'b000,0,0,0)) begin
                n_fail++;
                $display("FAIL halt_hold cyc%0d: got %h want %h", k, outs, pk(3'd7,0,2'b00,0,0,0,0,0,3'b000,0,0,0));
            end
        end
        Reset = 1'b0;
        #1;
        n_cmp++;
        if (state !== 3'd0 || illegal !== 1'b0 || IRWre !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_reset: state=%0d illegal=%b IRWre=%b want 0/0/0", state, illegal, IRWre);
        end
        step();
        Reset = 1'b1;
        step();
        n_cmp++;
        if (state !== 3'd1) begin
            n_fail++;
            $display("FAIL halt_restart: got %0d want 1", state);
        end
    endtask

    initial begin
        Reset  = 1'b0;
        opcode = 6'd0;
        zero   = 1'b0;
        test_reset();
        test_addi();
        test_lw();
        test_sw();
        test_alu_ops();
        test_branch();
        test_jump();
        test_reset_mid_lw();
        test_illegal();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
